// File: rtl/console_pkg.sv
// Shared types and register map for the memory-mapped console transmitter.
package console_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [31:0] OFF_DATA   = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS = 32'h0000_0004;

  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_FULL = 1;
  localparam int unsigned ST_OVF  = 2;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/console_tx.sv
// Console transmitter: DATA/STATUS register decode, byte FIFO and an 8N1 UART serializer.
module console_tx
  import console_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  tx_state_t             state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic [BYTE_W-1:0]     shreg_q, shreg_d;
  logic                  tx_q, tx_d;
  logic                  ovf_q, ovf_d;

  logic                  sel_data, sel_status;
  logic                  data_wr, status_wr;
  logic                  fifo_pop, fifo_full, fifo_empty;
  logic [BYTE_W-1:0]     fifo_dout;
  logic                  busy, div_end;
  logic                  unused_wdata;

  assign sel_data     = (addr == BASE_ADDR + OFF_DATA);
  assign sel_status   = (addr == BASE_ADDR + OFF_STATUS);
  assign data_wr      = we && sel_data;
  assign status_wr    = we && sel_status;
  assign busy         = !fifo_empty || (state_q != IDLE);
  assign div_end      = (div_q == DIV_LAST);
  assign unused_wdata = ^wdata[31:BYTE_W];

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (data_wr),
    .pop   (fifo_pop),
    .din   (wdata[BYTE_W-1:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky overflow: a dropped push sets it and wins over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (status_wr && wdata[ST_OVF]) ovf_d = 1'b0;
    if (data_wr && fifo_full)       ovf_d = 1'b1;
  end

  always_comb begin
    rdata = '0;
    if (sel_status) begin
      rdata[ST_BUSY] = busy;
      rdata[ST_FULL] = fifo_full;
      rdata[ST_OVF]  = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_dout;
          div_d    = '0;
          bit_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (div_end) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DATA: begin
        if (div_end) begin
          div_d   = '0;
          shreg_d = {1'b0, shreg_q[BYTE_W-1:1]};
          if (bit_q == BIT_CNT_W'(BYTE_W - 1)) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + BIT_CNT_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      STOP: begin
        if (div_end) begin
          div_d = '0;
          // Chain straight into the next start bit when a byte is waiting.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_dout;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is decoded from the upcoming state so the registered tx tracks state_q.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx = tx_q;

endmodule
